// File: rtl/periodic_grant_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | periodic_grant_scheduler: period tick + round-robin single-slot grant    |
// | with done/watchdog release and saturating overrun counter.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module periodic_grant_scheduler #(
  parameter int CLK_FREQ_MZ     = 100,
  parameter int TIMER_PERIOD_NS = 1000,
  parameter int N_REQ           = 4,
  parameter int TIMEOUT_CLK     = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ-1:0]         done_i,
  output logic                     tick_o,
  output logic [N_REQ-1:0]         grant_o,
  output logic [$clog2(N_REQ)-1:0] grant_id_o,
  output logic                     grant_active_o,
  output logic                     timeout_o,
  output logic [7:0]               overrun_cnt_o
);

  localparam int          C_NB_CLK   = CLK_FREQ_MZ * TIMER_PERIOD_NS / 1000;
  localparam int          C_CNT_W    = $clog2(C_NB_CLK);
  localparam int          C_ID_W     = $clog2(N_REQ);
  localparam int          C_WD_W     = (TIMEOUT_CLK > 1) ? $clog2(TIMEOUT_CLK) : 1;
  localparam int unsigned C_NREQ_U   = N_REQ;

  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_NB_CLK - 1);
  localparam logic [C_WD_W-1:0]  C_WD_LAST  = C_WD_W'(TIMEOUT_CLK - 1);
  localparam logic [N_REQ-1:0]   C_ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

  localparam logic [0:0] C_ST_IDLE  = 1'b0;
  localparam logic [0:0] C_ST_GRANT = 1'b1;

  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic [0:0]         state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [C_ID_W-1:0]  grant_id_q, grant_id_d;
  logic [C_ID_W-1:0]  rr_q, rr_d;
  logic [C_WD_W-1:0]  wd_q, wd_d;
  logic               timeout_q, timeout_d;
  logic [7:0]         ovr_q, ovr_d;

  logic               found;
  logic [C_ID_W-1:0]  winner;

  // Explicit modulo so non-power-of-2 N_REQ wraps correctly.
  function automatic logic [C_ID_W-1:0] f_wrap_add(input logic [C_ID_W-1:0] base,
                                                   input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= C_NREQ_U) sum = sum - C_NREQ_U;
    return C_ID_W'(sum);
  endfunction

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (!enable_i) begin
      cnt_d = '0;
    end else if (cnt_q == C_CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_i[f_wrap_add(rr_q, unsigned'(i))]) begin
        found  = 1'b1;
        winner = f_wrap_add(rr_q, unsigned'(i));
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    rr_d       = rr_q;
    wd_d       = wd_q;
    timeout_d  = 1'b0;
    ovr_d      = ovr_q;

    if (tick_q && (state_q == C_ST_GRANT) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end

    case (state_q)
      C_ST_IDLE: begin
        if (tick_q && enable_i && found) begin
          state_d    = C_ST_GRANT;
          grant_d    = C_ONE << winner;
          grant_id_d = winner;
          wd_d       = '0;
          rr_d       = f_wrap_add(winner, 1);
        end
      end
      C_ST_GRANT: begin
        // done takes priority over a watchdog expiry in the same cycle.
        if (done_i[grant_id_q]) begin
          state_d = C_ST_IDLE;
          grant_d = '0;
        end else if (wd_q == C_WD_LAST) begin
          state_d   = C_ST_IDLE;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: begin
        state_d = C_ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      state_q    <= C_ST_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      rr_q       <= '0;
      wd_q       <= '0;
      timeout_q  <= 1'b0;
      ovr_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      rr_q       <= rr_d;
      wd_q       <= wd_d;
      timeout_q  <= timeout_d;
      ovr_q      <= ovr_d;
    end
  end

  assign tick_o         = tick_q;
  assign grant_o        = grant_q;
  assign grant_id_o     = grant_id_q;
  assign grant_active_o = |grant_q;
  assign timeout_o      = timeout_q;
  assign overrun_cnt_o  = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_periodic_grant_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_periodic_grant_scheduler: directed self-checking bench.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_periodic_grant_scheduler;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NB_CLK=10, TIMEOUT_CLK=6
  logic       reset, enable;
  logic [3:0] req, done;
  logic       tick, grant_active, timeout;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic [7:0] overrun;

  // Instance B: NB_CLK=10, TIMEOUT_CLK=64
  logic       b_reset, b_enable;
  logic [3:0] b_req, b_done;
  logic       b_tick, b_grant_active, b_timeout;
  logic [3:0] b_grant;
  logic [1:0] b_grant_id;
  logic [7:0] b_overrun;

  int checks = 0;
  int failures = 0;

  periodic_grant_scheduler #(.CLK_FREQ_MZ(100), .TIMER_PERIOD_NS(100), .N_REQ(4), .TIMEOUT_CLK(6)) dut_a (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .req_i(req), .done_i(done),
    .tick_o(tick), .grant_o(grant), .grant_id_o(grant_id), .grant_active_o(grant_active),
    .timeout_o(timeout), .overrun_cnt_o(overrun));

  periodic_grant_scheduler #(.CLK_FREQ_MZ(100), .TIMER_PERIOD_NS(100), .N_REQ(4), .TIMEOUT_CLK(64)) dut_b (
    .clk_i(clk), .reset_i(b_reset), .enable_i(b_enable), .req_i(b_req), .done_i(b_done),
    .tick_o(b_tick), .grant_o(b_grant), .grant_id_o(b_grant_id), .grant_active_o(b_grant_active),
    .timeout_o(b_timeout), .overrun_cnt_o(b_overrun));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset_a();
    reset = 1'b1; enable = 1'b0; req = 4'b0; done = 4'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic wait_tick_a();
    int n = 0;
    while (tick !== 1'b1 && n < 40) begin step(); n++; end
    checks++;
    if (tick !== 1'b1) begin failures++; $display("FAIL wait_tick_a: tick=%b required 1 within 40 cycles", tick); end
  endtask

  task automatic wait_tick_b();
    int n = 0;
    while (b_tick !== 1'b1 && n < 40) begin step(); n++; end
    checks++;
    if (b_tick !== 1'b1) begin failures++; $display("FAIL wait_tick_b: tick=%b required 1 within 40 cycles", b_tick); end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; req = 4'b0; done = 4'b0;
    step(); step();
    checks++;
    if ({tick, grant, grant_id, grant_active, timeout, overrun} !== 17'b0) begin
      failures++;
      $display("FAIL reset_state: tick=%b grant=%b id=%0d act=%b to=%b ovr=%0d required all 0",
               tick, grant, grant_id, grant_active, timeout, overrun);
    end
  endtask

  task automatic test_tick_period();
    logic exp;
    do_reset_a();
    enable = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      exp = (k % 10 == 0);
      checks++;
      if (tick !== exp) begin failures++; $display("FAIL tick_period k=%0d: tick=%b required %b", k, tick, exp); end
      checks++;
      if (grant !== 4'b0) begin failures++; $display("FAIL idle_grant k=%0d: grant=%b required 0000", k, grant); end
    end
    checks++;
    if (overrun !== 8'd0) begin failures++; $display("FAIL idle_overrun: overrun=%0d required 0", overrun); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset_a();
    req = 4'b1111; enable = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_tick_a();
      step();
      checks++;
      if (grant !== exp_g[g] || grant_id !== exp_id[g] || grant_active !== 1'b1) begin
        failures++;
        $display("FAIL rr_grant %0d: grant=%b id=%0d act=%b required %b id=%0d act=1",
                 g, grant, grant_id, grant_active, exp_g[g], exp_id[g]);
      end
      step(); step();
      done = exp_g[g];
      step();
      done = 4'b0;
      checks++;
      if (grant !== 4'b0 || timeout !== 1'b0) begin
        failures++;
        $display("FAIL rr_release %0d: grant=%b timeout=%b required 0000 0", g, grant, timeout);
      end
    end
    checks++;
    if (overrun !== 8'd0) begin failures++; $display("FAIL rr_overrun: overrun=%0d required 0", overrun); end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    do_reset_a();
    req = 4'b0100; enable = 1'b1;
    wait_tick_a();
    step();
    checks++;
    if (grant_id !== 2'd2) begin failures++; $display("FAIL to_grant_id: id=%0d required 2", grant_id); end
    while (grant === 4'b0100 && cnt < 20) begin
      checks++;
      if (timeout !== 1'b0) begin failures++; $display("FAIL to_early: timeout=%b required 0 at %0d", timeout, cnt); end
      cnt++; step();
    end
    checks++;
    if (cnt != 6) begin failures++; $display("FAIL to_length: grant cycles=%0d required 6", cnt); end
    checks++;
    if (timeout !== 1'b1 || grant_active !== 1'b0) begin
      failures++; $display("FAIL to_pulse: timeout=%b act=%b required 1 0", timeout, grant_active);
    end
    step();
    checks++;
    if (timeout !== 1'b0) begin failures++; $display("FAIL to_width: timeout=%b required 0", timeout); end
  endtask

  task automatic test_done_at_limit();
    do_reset_a();
    req = 4'b0001; enable = 1'b1;
    wait_tick_a();
    step();
    for (int i = 0; i < 5; i++) step();
    done = 4'b0001;
    step();
    done = 4'b0;
    checks++;
    if (grant !== 4'b0 || timeout !== 1'b0) begin
      failures++; $display("FAIL done_at_limit: grant=%b timeout=%b required 0000 0", grant, timeout);
    end
  endtask

  task automatic test_foreign_done();
    do_reset_a();
    req = 4'b0001; enable = 1'b1;
    wait_tick_a();
    step();
    done = 4'b0100;
    step();
    done = 4'b0;
    checks++;
    if (grant !== 4'b0001) begin failures++; $display("FAIL foreign_done: grant=%b required 0001", grant); end
    req = 4'b0000;
    step();
    checks++;
    if (grant !== 4'b0001) begin failures++; $display("FAIL req_drop: grant=%b required 0001", grant); end
    done = 4'b0001;
    step();
    done = 4'b0;
    checks++;
    if (grant !== 4'b0 || timeout !== 1'b0) begin
      failures++; $display("FAIL own_done: grant=%b timeout=%b required 0000 0", grant, timeout);
    end
  endtask

  task automatic test_async_reset();
    int k = 0;
    do_reset_a();
    req = 4'b0010; enable = 1'b1;
    wait_tick_a();
    step(); step(); step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0 || tick !== 1'b0 || grant_active !== 1'b0 || timeout !== 1'b0) begin
      failures++; $display("FAIL async_reset: grant=%b tick=%b act=%b to=%b required all 0", grant, tick, grant_active, timeout);
    end
    req = 4'b1111;
    step();
    reset = 1'b0;
    while (tick !== 1'b1 && k < 30) begin step(); k++; end
    checks++;
    if (k != 10) begin failures++; $display("FAIL post_reset_tick: first tick after %0d cycles required 10", k); end
    step();
    checks++;
    if (grant !== 4'b0001 || grant_id !== 2'd0) begin
      failures++; $display("FAIL post_reset_rr: grant=%b id=%0d required 0001 id=0", grant, grant_id);
    end
  endtask

  task automatic test_overrun_sat();
    b_reset = 1'b0; b_enable = 1'b1; b_req = 4'b0001; b_done = 4'b0;
    wait_tick_b();
    step();
    checks++;
    if (b_grant !== 4'b0001 || b_overrun !== 8'd0) begin
      failures++; $display("FAIL ovr_start: grant=%b overrun=%0d required 0001 0", b_grant, b_overrun);
    end
    for (int j = 1; j <= 3; j++) begin
      wait_tick_b();
      step();
      checks++;
      if (b_overrun !== 8'(j)) begin failures++; $display("FAIL ovr_inc %0d: overrun=%0d required %0d", j, b_overrun, j); end
    end
    for (int t = 0; t < 330; t++) begin
      wait_tick_b();
      step();
    end
    checks++;
    if (b_overrun !== 8'd255) begin failures++; $display("FAIL ovr_sat: overrun=%0d required 255", b_overrun); end
  endtask

  initial begin
    b_reset = 1'b1; b_enable = 1'b0; b_req = 4'b0; b_done = 4'b0;
    test_reset();
    test_tick_period();
    test_round_robin();
    test_timeout();
    test_done_at_limit();
    test_foreign_done();
    test_async_reset();
    test_overrun_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
